// File: rtl/rf_pkg.sv
// Register-file scoreboard shared definitions, reused by decode and write-back.
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } sb_state_t;

    // One-hot select for a register; x0 is hard-wired and never tracked.
    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] m;
        m       = '0;
        m[addr] = 1'b1;
        m[0]    = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Register-file scoreboard: per-register pending-write bits, RAW/WAW issue
// interlock, outstanding-write counter and a flush/drain FSM.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int MAX_PENDING = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rs1,
    input  logic [REG_ADDR_W-1:0] issue_rs2,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  issue_rd_we,
    output logic                  issue_ready,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  flush,
    output logic [NUM_REGS-1:0]   busy,
    output logic [5:0]            pending_cnt,
    output logic                  draining,
    output logic                  wb_err
);

    sb_state_t           state;
    logic                rd_tracked;
    logic                rd_hazard;
    logic                set_en;
    logic                clr_en;
    logic                wb_spurious;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [5:0]          cnt_nxt;

    // Issue interlock from registered busy only, so a same-cycle write-back
    // never releases a hazard.
    always_comb begin
        rd_tracked  = issue_rd_we && (issue_rd != '0);
        rd_hazard   = rd_tracked &&
                      (busy[issue_rd] || (pending_cnt >= 6'(MAX_PENDING)));
        issue_ready = (state != DRAIN) && !flush &&
                      !busy[issue_rs1] && !busy[issue_rs2] && !rd_hazard;
    end

    // Next busy vector and count; set and clear never hit the same register
    // because the WAW check blocks issue to a busy rd.
    always_comb begin
        set_en      = issue_valid && issue_ready && rd_tracked;
        clr_en      = wb_valid && busy[wb_rd];
        wb_spurious = wb_valid && !busy[wb_rd];
        busy_nxt    = busy;
        if (set_en) busy_nxt = busy_nxt | reg_mask(issue_rd);
        if (clr_en) busy_nxt = busy_nxt & ~reg_mask(wb_rd);
        cnt_nxt     = pending_cnt + {5'd0, set_en} - {5'd0, clr_en};
    end

    // Busy bits, outstanding count and sticky write-back error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= '0;
            pending_cnt <= '0;
            wb_err      <= 1'b0;
        end else begin
            busy        <= busy_nxt;
            pending_cnt <= cnt_nxt;
            if (wb_spurious) wb_err <= 1'b1;
        end
    end

    // Scoreboard FSM; draining is registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            draining <= 1'b0;
        end else begin
            case (state)
                IDLE, ACTIVE: begin
                    if (flush) begin
                        state    <= (cnt_nxt != '0) ? DRAIN : IDLE;
                        draining <= (cnt_nxt != '0);
                    end else begin
                        state    <= (cnt_nxt != '0) ? ACTIVE : IDLE;
                        draining <= 1'b0;
                    end
                end
                DRAIN: begin
                    // Further flushes are ignored; only retirement leaves DRAIN.
                    if (cnt_nxt == '0) begin
                        state    <= IDLE;
                        draining <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    draining <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard: a reference model pushes expected
// register state into a queue each cycle, popped and compared after the edge.
module tb_rf_scoreboard;

    localparam int MAXP = 4;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic [4:0]  issue_rd;
    logic        issue_rd_we;
    logic        issue_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic [31:0] busy;
    logic [5:0]  pending_cnt;
    logic        draining;
    logic        wb_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] busy;
        logic [5:0]  cnt;
        logic        err;
        logic        drain;
    } exp_t;

    exp_t exp_q[$];

    // reference model (state: 0 idle, 1 active, 2 drain)
    logic [31:0] m_busy;
    int          m_cnt;
    logic        m_err;
    int          m_state;

    rf_scoreboard #(.MAX_PENDING(MAXP)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_rd_we(issue_rd_we), .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .busy(busy), .pending_cnt(pending_cnt), .draining(draining), .wb_err(wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic model_reset();
        m_busy  = '0;
        m_cnt   = 0;
        m_err   = 1'b0;
        m_state = 0;
        exp_q.delete();
    endtask

    task automatic idle_in();
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        issue_rd_we = 0; wb_valid = 0; wb_rd = 0; flush = 0;
    endtask

    function automatic logic model_ready();
        logic rd_h;
        rd_h = issue_rd_we && (issue_rd != 0) && (m_busy[issue_rd] || m_cnt >= MAXP);
        return (m_state != 2) && !flush && !m_busy[issue_rs1] && !m_busy[issue_rs2] && !rd_h;
    endfunction

    // One clock: check issue_ready, predict, clock, pop and compare.
    task automatic step(output logic rdy);
        exp_t        e;
        logic        m_rdy;
        logic        set;
        logic        clr;
        logic [31:0] nb;
        #1;
        m_rdy = model_ready();
        rdy   = issue_ready;
        checks++;
        if (issue_ready !== m_rdy) begin
            errors++;
            $display("FAIL issue_ready @%0t: got %b expected %b", $time, issue_ready, m_rdy);
        end
        set = issue_valid && m_rdy && issue_rd_we && (issue_rd != 0);
        clr = wb_valid && m_busy[wb_rd];
        if (wb_valid && !m_busy[wb_rd]) m_err = 1'b1;
        nb = m_busy;
        if (set) nb[issue_rd] = 1'b1;
        if (clr) nb[wb_rd] = 1'b0;
        m_busy = nb;
        m_cnt  = $countones(nb);
        if (m_state == 2) m_state = (m_cnt == 0) ? 0 : 2;
        else if (flush)   m_state = (m_cnt == 0) ? 0 : 2;
        else              m_state = (m_cnt == 0) ? 0 : 1;
        e.busy = m_busy; e.cnt = 6'(m_cnt); e.err = m_err; e.drain = (m_state == 2);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: queue empty at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            if (busy !== e.busy || pending_cnt !== e.cnt || wb_err !== e.err || draining !== e.drain) begin
                errors++;
                $display("FAIL state @%0t: got busy=%h cnt=%0d err=%b drain=%b expected busy=%h cnt=%0d err=%b drain=%b",
                         $time, busy, pending_cnt, wb_err, draining, e.busy, e.cnt, e.err, e.drain);
            end
        end
        idle_in();
    endtask

    task automatic issue_wr(input logic [4:0] rd);
        logic r;
        issue_valid = 1; issue_rd_we = 1; issue_rd = rd;
        step(r);
    endtask

    task automatic wback(input logic [4:0] rd);
        logic r;
        wb_valid = 1; wb_rd = rd;
        step(r);
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_in();
        model_reset();
        issue_valid = 1; issue_rd_we = 1; issue_rd = 1;
        #3;
        checks++;
        if (busy !== 32'h0 || pending_cnt !== 6'd0 || wb_err !== 1'b0 || draining !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%h cnt=%0d err=%b drain=%b expected all zero",
                     busy, pending_cnt, wb_err, draining);
        end
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", issue_ready);
        end
        idle_in();
        @(posedge clk); #2;
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_raw();
        logic r;
        issue_wr(5);
        issue_valid = 1; issue_rs1 = 5;
        wb_valid = 1; wb_rd = 5;
        step(r);
        checks++;
        if (r !== 1'b0) begin errors++; $display("FAIL raw_stall: got ready=%b expected 0", r); end
        issue_valid = 1; issue_rs1 = 5;
        step(r);
        checks++;
        if (r !== 1'b1) begin errors++; $display("FAIL raw_release: got ready=%b expected 1", r); end
        checks++;
        if (busy[5] !== 1'b0) begin errors++; $display("FAIL raw_busy5: got %b expected 0", busy[5]); end
    endtask

    task automatic test_capacity();
        logic r;
        for (int i = 1; i <= 4; i++) issue_wr(5'(i));
        checks++;
        if (pending_cnt !== 6'd4) begin errors++; $display("FAIL cap_cnt: got %0d expected 4", pending_cnt); end
        issue_valid = 1; issue_rd_we = 1; issue_rd = 6;
        step(r);
        checks++;
        if (r !== 1'b0 || busy[6] !== 1'b0) begin
            errors++; $display("FAIL cap_full: got ready=%b busy6=%b expected 0 0", r, busy[6]);
        end
        issue_valid = 1; issue_rs1 = 7; issue_rs2 = 8;
        step(r);
        checks++;
        if (r !== 1'b1) begin errors++; $display("FAIL cap_readonly: got ready=%b expected 1", r); end
        for (int i = 1; i <= 4; i++) wback(5'(i));
    endtask

    task automatic test_simultaneous();
        logic r;
        issue_wr(2);
        issue_valid = 1; issue_rd_we = 1; issue_rd = 3;
        wb_valid = 1; wb_rd = 2;
        step(r);
        checks++;
        if (pending_cnt !== 6'd1 || busy[3] !== 1'b1 || busy[2] !== 1'b0) begin
            errors++;
            $display("FAIL simul: got cnt=%0d busy3=%b busy2=%b expected 1 1 0", pending_cnt, busy[3], busy[2]);
        end
        wback(3);
    endtask

    task automatic test_x0_spurious();
        logic r;
        issue_valid = 1; issue_rd_we = 1; issue_rd = 0;
        step(r);
        checks++;
        if (r !== 1'b1 || busy !== 32'h0 || pending_cnt !== 6'd0) begin
            errors++;
            $display("FAIL x0: got ready=%b busy=%h cnt=%0d expected 1 0 0", r, busy, pending_cnt);
        end
        wback(9);
        step(r);
        step(r);
        checks++;
        if (wb_err !== 1'b1 || busy !== 32'h0) begin
            errors++; $display("FAIL spurious_wb: got err=%b busy=%h expected 1 0", wb_err, busy);
        end
    endtask

    task automatic test_flush();
        logic r;
        flush = 1;
        step(r);
        checks++;
        if (draining !== 1'b0) begin errors++; $display("FAIL flush_idle: got drain=%b expected 0", draining); end
        for (int i = 1; i <= 3; i++) issue_wr(5'(i));
        flush = 1; issue_valid = 1; issue_rd_we = 1; issue_rd = 10;
        step(r);
        checks++;
        if (r !== 1'b0 || draining !== 1'b1 || busy[10] !== 1'b0) begin
            errors++; $display("FAIL flush_drain: got ready=%b drain=%b busy10=%b expected 0 1 0", r, draining, busy[10]);
        end
        issue_valid = 1; issue_rs1 = 20;
        step(r);
        checks++;
        if (r !== 1'b0) begin errors++; $display("FAIL drain_block: got ready=%b expected 0", r); end
        wback(1);
        flush = 1;
        step(r);
        wback(2);
        checks++;
        if (draining !== 1'b1 || pending_cnt !== 6'd1) begin
            errors++; $display("FAIL drain_hold: got drain=%b cnt=%0d expected 1 1", draining, pending_cnt);
        end
        wback(3);
        checks++;
        if (draining !== 1'b0 || pending_cnt !== 6'd0) begin
            errors++; $display("FAIL drain_exit: got drain=%b cnt=%0d expected 0 0", draining, pending_cnt);
        end
    endtask

    task automatic test_reset_mid_drain();
        logic r;
        issue_wr(4);
        issue_wr(5);
        flush = 1;
        step(r);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        checks++;
        if (busy !== 32'h0 || pending_cnt !== 6'd0 || draining !== 1'b0 || wb_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got busy=%h cnt=%0d drain=%b err=%b expected 0 0 0 0",
                     busy, pending_cnt, draining, wb_err);
        end
        #2;
        rst_n = 1;
        @(posedge clk); #1;
        wback(4);
        checks++;
        if (wb_err !== 1'b1) begin errors++; $display("FAIL post_reset_wb: got err=%b expected 1", wb_err); end
    endtask

    task automatic test_back_to_back();
        logic r;
        for (int k = 0; k < 40; k++) begin
            issue_valid = 1'($urandom_range(0, 1));
            issue_rs1   = 5'($urandom_range(0, 15));
            issue_rs2   = 5'($urandom_range(0, 15));
            issue_rd    = 5'($urandom_range(0, 15));
            issue_rd_we = 1'($urandom_range(0, 1));
            wb_valid    = 1'($urandom_range(0, 1));
            wb_rd       = 5'($urandom_range(0, 15));
            flush       = ($urandom_range(0, 9) == 0);
            step(r);
        end
        for (int i = 1; i < 32; i++) if (m_busy[i]) wback(5'(i));
    endtask

    initial begin
        test_reset();
        test_raw();
        test_capacity();
        test_simultaneous();
        test_x0_spurious();
        test_flush();
        test_reset_mid_drain();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
